// File: rtl/qec_stim_pkg.sv
// Shared definitions for the round stimulus timer: FSM encoding, LFSR taps,
// lane seeding and the Galois step used by every lane.
package qec_stim_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GEN     = 3'd1;
    localparam logic [2:0] ST_OFFER   = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        GEN     = ST_GEN,
        OFFER   = ST_OFFER,
        MEASURE = ST_MEASURE,
        DONE    = ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] GOLDEN_SEED = 32'h9E37_79B9;

    function automatic logic [31:0] galois_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned idx);
        logic [31:0] s;
        s = base ^ (idx * GOLDEN_SEED);
        return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
    endfunction

endpackage

// File: rtl/round_stimulus_timer_if.sv
// Bundles the communicator-facing and decoder-facing signals of the stimulus timer.
interface round_stimulus_timer_if #(
    parameter int unsigned NUM_QUBITS = 64
);
    logic                  new_round_start;
    logic [NUM_QUBITS-1:0] error_pattern;
    logic                  pattern_valid;
    logic                  pattern_ready;
    logic                  decoder_done;
    logic                  decoder_error;
    logic                  result_valid;
    logic [31:0]           duration;
    logic                  error_detected;
    logic                  timeout;
    logic                  round_overrun;

    modport master (
        input  new_round_start, pattern_ready, decoder_done, decoder_error,
        output error_pattern, pattern_valid, result_valid, duration,
               error_detected, timeout, round_overrun
    );

    modport slave (
        output new_round_start, pattern_ready, decoder_done, decoder_error,
        input  error_pattern, pattern_valid, result_valid, duration,
               error_detected, timeout, round_overrun
    );
endinterface

// File: rtl/lfsr32_lane.sv
// One 32-bit Galois LFSR lane; advances one step per enabled cycle, reseeds only on reset.
module lfsr32_lane
    import qec_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [31:0] state
);
    logic [31:0] state_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SEED;
        end else if (step) begin
            state_r <= galois_step(state_r);
        end
    end

    assign state = state_r;
endmodule

// File: rtl/round_stimulus_timer.sv
// Generates a random per-qubit error pattern each round, offers it to the decoder
// and times the decode, latching duration and error status for the communicator.
module round_stimulus_timer
    import qec_stim_pkg::*;
#(
    parameter int unsigned NUM_QUBITS     = 64,
    parameter int unsigned LANES          = 8,
    parameter logic [15:0] ERR_THRESHOLD  = 16'd655,
    parameter logic [31:0] DURATION_CAP   = 32'd1023,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576,
    parameter logic [31:0] SEED           = 32'h1234_5678
) (
    input  logic                   clk,
    input  logic                   reset,
    round_stimulus_timer_if.master bus
);
    localparam int unsigned     GEN_CYCLES = NUM_QUBITS / LANES;
    localparam int unsigned     IDX_W      = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] GEN_LAST  = IDX_W'(GEN_CYCLES - 1);

    logic [2:0]            state_r;
    logic [IDX_W-1:0]      gen_idx_r;
    logic [31:0]           cnt_r;
    logic [NUM_QUBITS-1:0] pattern_r;
    logic                  pattern_valid_r;
    logic                  result_valid_r;
    logic [31:0]           duration_r;
    logic                  error_detected_r;
    logic                  timeout_r;
    logic                  round_overrun_r;

    logic [31:0]      lane_state_s [LANES];
    logic [LANES-1:0] lane_err_s;
    logic             lane_step_s;
    logic [32:0]      cnt_inc_s;
    logic [31:0]      dur_sat_s;
    logic             timeout_hit_s;
    logic             overrun_hit_s;

    assign lane_step_s = (state_r == ST_GEN);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [15:0] next_lo_s;
        logic [16:0] diff_s;

        lfsr32_lane #(
            .SEED (lane_seed(SEED, i))
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .step  (lane_step_s),
            .state (lane_state_s[i])
        );

        // Borrow out of (lane value - threshold) marks the qubit as errored.
        assign next_lo_s     = 16'(galois_step(lane_state_s[i]));
        assign diff_s        = {1'b0, next_lo_s} - {1'b0, ERR_THRESHOLD};
        assign lane_err_s[i] = diff_s[16];
    end

    // Counter increment is widened so timeout compare and saturation never see a wrap.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + 33'd1;
        if (cnt_inc_s > {1'b0, DURATION_CAP}) begin
            dur_sat_s = DURATION_CAP;
        end else begin
            dur_sat_s = cnt_inc_s[31:0];
        end
    end

    assign timeout_hit_s = (cnt_inc_s == {1'b0, TIMEOUT_CYCLES});
    assign overrun_hit_s = bus.new_round_start &&
                           ((state_r == ST_GEN) || (state_r == ST_OFFER) || (state_r == ST_MEASURE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            gen_idx_r        <= '0;
            cnt_r            <= 32'd0;
            pattern_r        <= '0;
            pattern_valid_r  <= 1'b0;
            result_valid_r   <= 1'b0;
            duration_r       <= 32'd0;
            error_detected_r <= 1'b0;
            timeout_r        <= 1'b0;
            round_overrun_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.new_round_start) begin
                        state_r        <= ST_GEN;
                        result_valid_r <= 1'b0;
                        timeout_r      <= 1'b0;
                        gen_idx_r      <= '0;
                    end
                end
                ST_GEN: begin
                    pattern_r[gen_idx_r * LANES +: LANES] <= lane_err_s;
                    if (gen_idx_r == GEN_LAST) begin
                        state_r         <= ST_OFFER;
                        pattern_valid_r <= 1'b1;
                    end else begin
                        gen_idx_r <= gen_idx_r + IDX_W'(1);
                    end
                end
                // decoder_done during the handshake belongs to no round and is dropped.
                ST_OFFER: begin
                    if (bus.pattern_ready) begin
                        pattern_valid_r <= 1'b0;
                        cnt_r           <= 32'd0;
                        state_r         <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (bus.decoder_done) begin
                        duration_r       <= dur_sat_s;
                        error_detected_r <= bus.decoder_error;
                        result_valid_r   <= 1'b1;
                        state_r          <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_inc_s[31:0];
                        if (timeout_hit_s) begin
                            duration_r       <= DURATION_CAP;
                            error_detected_r <= 1'b1;
                            timeout_r        <= 1'b1;
                            result_valid_r   <= 1'b1;
                            state_r          <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    pattern_valid_r <= 1'b0;
                end
            endcase

            if (overrun_hit_s) begin
                round_overrun_r <= 1'b1;
            end
        end
    end

    assign bus.error_pattern  = pattern_r;
    assign bus.pattern_valid  = pattern_valid_r;
    assign bus.result_valid   = result_valid_r;
    assign bus.duration       = duration_r;
    assign bus.error_detected = error_detected_r;
    assign bus.timeout        = timeout_r;
    assign bus.round_overrun  = round_overrun_r;
endmodule

// File: tb/tb_round_stimulus_timer.sv
// Self-checking bench: four timer instances with different thresholds/timeouts share
// one stimulus stream and are compared against an independent LFSR/timing model.
module tb_round_stimulus_timer;
    localparam int NQ      = 64;
    localparam int LN      = 8;
    localparam int CAP     = 1023;
    localparam int TO_FULL = 100;
    localparam int TO_DEF  = 1048576;

    typedef struct {
        int rdy_dly;
        int done_k;
        bit derr;
        int ovr_at;
        int dur_m;
        bit ed_m;
        int dur_f;
        bit ed_f;
        bit to_f;
    } vec_t;

    logic clk = 1'b0;
    logic reset, nrs, rdy, done, derr;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] lane [LN];
    logic [63:0] prev_half;
    bit   have_prev = 1'b0;
    bit   exp_ovr   = 1'b0;

    always #5 clk = ~clk;

    round_stimulus_timer_if #(.NUM_QUBITS(NQ)) if_main ();
    round_stimulus_timer_if #(.NUM_QUBITS(NQ)) if_zero ();
    round_stimulus_timer_if #(.NUM_QUBITS(NQ)) if_full ();
    round_stimulus_timer_if #(.NUM_QUBITS(NQ)) if_half ();

    assign {if_main.new_round_start, if_zero.new_round_start, if_full.new_round_start, if_half.new_round_start} = {4{nrs}};
    assign {if_main.pattern_ready, if_zero.pattern_ready, if_full.pattern_ready, if_half.pattern_ready} = {4{rdy}};
    assign {if_main.decoder_done, if_zero.decoder_done, if_full.decoder_done, if_half.decoder_done} = {4{done}};
    assign {if_main.decoder_error, if_zero.decoder_error, if_full.decoder_error, if_half.decoder_error} = {4{derr}};

    round_stimulus_timer u_main (.clk(clk), .reset(reset), .bus(if_main.master));
    round_stimulus_timer #(.ERR_THRESHOLD(16'd0)) u_zero (.clk(clk), .reset(reset), .bus(if_zero.master));
    round_stimulus_timer #(.ERR_THRESHOLD(16'hFFFF), .TIMEOUT_CYCLES(32'd100))
        u_full (.clk(clk), .reset(reset), .bus(if_full.master));
    round_stimulus_timer #(.ERR_THRESHOLD(16'h8000)) u_half (.clk(clk), .reset(reset), .bus(if_half.master));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic model_reseed();
        for (int i = 0; i < LN; i++) begin
            lane[i] = 32'h1234_5678 ^ (32'(i) * 32'h9E37_79B9);
            if (lane[i] == 32'd0) lane[i] = 32'd1;
        end
    endtask

    // One round of generation: NQ/LN steps of every lane, one bit per lane per step.
    task automatic model_gen(output logic [63:0] pm, output logic [63:0] pz,
                             output logic [63:0] pf, output logic [63:0] ph);
        int v;
        for (int g = 0; g < NQ / LN; g++) begin
            for (int i = 0; i < LN; i++) begin
                lane[i] = lfsr_next(lane[i]);
                v = int'(lane[i][15:0]);
                pm[g * LN + i] = (v < 655);
                pz[g * LN + i] = (v < 0);
                pf[g * LN + i] = (v < 65535);
                ph[g * LN + i] = (v < 32768);
            end
        end
    endtask

    task automatic expect_res(input int dk, input bit de, input int tmo,
                              output int dur, output bit ed, output bit to);
        if (dk <= tmo) begin
            dur = (dk < CAP) ? dk : CAP;
            ed  = de;
            to  = 1'b0;
        end else begin
            dur = CAP;
            ed  = 1'b1;
            to  = 1'b1;
        end
    endtask

    task automatic do_round(input int rdy_dly, input int done_k, input bit de, input int ovr_at,
                            input int dur_m, input bit ed_m, input int dur_f, input bit ed_f, input bit to_f);
        int n;
        logic [63:0] pm, pz, pf, ph;
        nrs = 1'b1;
        tick();
        nrs = 1'b0;
        check("rv_low_at_start", if_main.result_valid, 0);
        check("to_clear_at_start", if_full.timeout, 0);
        model_gen(pm, pz, pf, ph);
        n = 0;
        while (!if_main.pattern_valid && n < 20) begin
            tick();
            n++;
        end
        check("gen_cycles", n, NQ / LN);
        check("pattern_main", if_main.error_pattern, pm);
        check("pattern_zero", if_zero.error_pattern, pz);
        check("pattern_full", if_full.error_pattern, pf);
        check("pattern_half", if_half.error_pattern, ph);
        if (have_prev) check("pattern_differs", (if_half.error_pattern != prev_half), 1);
        prev_half = ph;
        have_prev = 1'b1;
        repeat (rdy_dly) tick();
        check("pv_hold", if_main.pattern_valid, 1);
        check("pattern_hold", if_main.error_pattern, pm);
        rdy = 1'b1; done = 1'b1; derr = 1'b1;
        tick();
        rdy = 1'b0; done = 1'b0; derr = 1'b0;
        check("pv_drop_main", if_main.pattern_valid, 0);
        check("pv_drop_full", if_full.pattern_valid, 0);
        for (int k = 1; k <= done_k; k++) begin
            done = (k == done_k);
            derr = de;
            nrs  = (k == ovr_at);
            tick();
            nrs = 1'b0;
            if (k == done_k - 1) check("rv_early", if_main.result_valid, 0);
            if (done_k > TO_FULL && k == TO_FULL - 1) check("rv_before_timeout", if_full.result_valid, 0);
            if (done_k > TO_FULL && k == TO_FULL) check("timeout_edge", if_full.timeout, 1);
        end
        done = 1'b0;
        derr = 1'b0;
        if (ovr_at > 0) exp_ovr = 1'b1;
        check("rv_main", if_main.result_valid, 1);
        check("dur_main", if_main.duration, dur_m);
        check("ed_main", if_main.error_detected, ed_m);
        check("to_main", if_main.timeout, 0);
        check("dur_zero", if_zero.duration, dur_m);
        check("ed_half", if_half.error_detected, ed_m);
        check("rv_full", if_full.result_valid, 1);
        check("dur_full", if_full.duration, dur_f);
        check("ed_full", if_full.error_detected, ed_f);
        check("to_full", if_full.timeout, to_f);
        check("overrun_main", if_main.round_overrun, exp_ovr);
        check("overrun_full", if_full.round_overrun, exp_ovr);
        repeat (2) tick();
        check("rv_hold", if_main.result_valid, 1);
        check("dur_hold", if_main.duration, dur_m);
        check("pattern_keep", if_main.error_pattern, pm);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        int rd, dk, dm, df;
        bit de, em, ef, tf;

        vecs[0] = '{3, 5,    1'b1, 0, 5,    1'b1, 5,    1'b1, 1'b0};
        vecs[1] = '{0, 2000, 1'b0, 0, 1023, 1'b0, 1023, 1'b1, 1'b1};
        vecs[2] = '{1, 1,    1'b0, 0, 1,    1'b0, 1,    1'b0, 1'b0};
        vecs[3] = '{2, 100,  1'b0, 0, 100,  1'b0, 100,  1'b0, 1'b0};
        vecs[4] = '{0, 1024, 1'b1, 0, 1023, 1'b1, 1023, 1'b1, 1'b1};
        vecs[5] = '{4, 7,    1'b0, 3, 7,    1'b0, 7,    1'b0, 1'b0};
        vecs[6] = '{0, 99,   1'b1, 0, 99,   1'b1, 99,   1'b1, 1'b0};

        reset = 1'b1; nrs = 1'b0; rdy = 1'b0; done = 1'b0; derr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        model_reseed();
        tick();
        check("rst_pv", if_main.pattern_valid, 0);
        check("rst_rv", if_main.result_valid, 0);
        check("rst_dur", if_main.duration, 0);
        check("rst_ed", if_main.error_detected, 0);
        check("rst_to", if_main.timeout, 0);
        check("rst_ovr", if_main.round_overrun, 0);
        check("rst_pattern", if_main.error_pattern, 0);
        check("rst_pattern_full", if_full.error_pattern, 0);

        for (int v = 0; v < 7; v++) begin
            do_round(vecs[v].rdy_dly, vecs[v].done_k, vecs[v].derr, vecs[v].ovr_at,
                     vecs[v].dur_m, vecs[v].ed_m, vecs[v].dur_f, vecs[v].ed_f, vecs[v].to_f);
        end

        for (int r = 0; r < 6; r++) begin
            rd = $urandom_range(0, 5);
            dk = $urandom_range(1, 160);
            de = 1'($urandom_range(0, 1));
            expect_res(dk, de, TO_DEF, dm, em, tf);
            expect_res(dk, de, TO_FULL, df, ef, tf);
            do_round(rd, dk, de, 0, dm, em, df, ef, tf);
        end

        // Reset while the pattern is being offered.
        nrs = 1'b1;
        tick();
        nrs = 1'b0;
        repeat (NQ / LN) tick();
        check("pv_before_reset", if_main.pattern_valid, 1);
        reset = 1'b1;
        tick();
        check("pv_in_reset", if_main.pattern_valid, 0);
        check("pattern_in_reset", if_main.error_pattern, 0);
        check("ovr_in_reset", if_main.round_overrun, 0);
        check("rv_in_reset", if_full.result_valid, 0);
        check("dur_in_reset", if_full.duration, 0);
        reset = 1'b0;
        model_reseed();
        exp_ovr = 1'b0;
        tick();
        do_round(1, 10, 1'b1, 0, 10, 1'b1, 10, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
